spike_event_extractor: RTL and testbench



---
 rtl/spike_event_extractor.sv | 205 ++++++++++++++++++++
 tb/tb_spike_event_extractor.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_event_extractor.sv
// spike_event_extractor: turns each run of above-threshold samples on a channel
// into a single peak event, enforces a per-channel refractory holdoff, and queues
// events in a first-word-fall-through FIFO drained by an AXI-Stream-style master.
// Optional build macro SPIKE_DROP_COUNT_EN adds a saturating drop_count output.
module spike_event_extractor #(
  parameter int CHANNEL_COUNT  = 32,
  parameter int DATA_WIDTH     = 16,
  parameter int TIME_WIDTH     = 32,
  parameter int REFRACTORY_LEN = 30,
  parameter int MAX_WIDTH      = 40,
  parameter int FIFO_DEPTH     = 16,
  parameter int CW             = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [TIME_WIDTH-1:0] s_axis_b_time,
  input  logic [CW-1:0]         s_axis_b_tchannel,
  input  logic [DATA_WIDTH-1:0] s_axis_b_tdata,
  input  logic                  s_axis_b_tsample,
  input  logic                  s_axis_b_tvalid,
  output logic [TIME_WIDTH-1:0] m_axis_c_time,
  output logic [CW-1:0]         m_axis_c_tchannel,
  output logic [DATA_WIDTH-1:0] m_axis_c_tdata,
  output logic                  m_axis_c_tvalid,
  input  logic                  m_axis_c_tready,
  output logic                  overflow
`ifdef SPIKE_DROP_COUNT_EN
  ,
  output logic [15:0]           drop_count
`endif
);

  localparam int          AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int          EW        = TIME_WIDTH + CW + DATA_WIDTH;
  localparam logic [7:0]  MAX_CNT   = 8'(MAX_WIDTH);
  localparam logic [7:0]  REF_CNT   = 8'(REFRACTORY_LEN);
  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OPEN   = 2'd1,
    ST_REFRAC = 2'd2
  } ch_state_e;

  // Per-channel context
  ch_state_e             state_q     [CHANNEL_COUNT];
  logic [DATA_WIDTH-1:0] peak_amp_q  [CHANNEL_COUNT];
  logic [TIME_WIDTH-1:0] peak_time_q [CHANNEL_COUNT];
  logic [7:0]            cnt_q       [CHANNEL_COUNT];

  ch_state_e             cur_state, state_d;
  logic [DATA_WIDTH-1:0] cur_amp, amp_d;
  logic [TIME_WIDTH-1:0] cur_time, time_d;
  logic [7:0]            cur_cnt, cnt_d, cnt_inc;
  logic                  emit_s;
  logic [EW-1:0]         ev_word_s;

  // Event FIFO
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          valid_q;
  logic          full_s, pop_s, push_s, drop_s;
  logic          overflow_q;
  logic [EW-1:0] head_s;

  // Read-modify-write of the addressed channel context for the current sample
  always_comb begin
    cur_state = state_q[s_axis_b_tchannel];
    cur_amp   = peak_amp_q[s_axis_b_tchannel];
    cur_time  = peak_time_q[s_axis_b_tchannel];
    cur_cnt   = cnt_q[s_axis_b_tchannel];
    cnt_inc   = (cur_cnt == 8'hFF) ? cur_cnt : cur_cnt + 8'd1;
    state_d   = cur_state;
    amp_d     = cur_amp;
    time_d    = cur_time;
    cnt_d     = cur_cnt;
    emit_s    = 1'b0;
    if (s_axis_b_tsample) begin
      case (cur_state)
        ST_IDLE: begin
          if (s_axis_b_tvalid) begin
            state_d = ST_OPEN;
            amp_d   = s_axis_b_tdata;
            time_d  = s_axis_b_time;
            cnt_d   = 8'd1;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_OPEN: begin
          if (s_axis_b_tvalid) begin
            // strict compare: a tie keeps the earlier peak
            if (s_axis_b_tdata > cur_amp) begin
              amp_d  = s_axis_b_tdata;
              time_d = s_axis_b_time;
            end else begin
              amp_d  = cur_amp;
            end
            if (cnt_inc == MAX_CNT) begin
              emit_s  = 1'b1;
              state_d = ST_REFRAC;
              cnt_d   = REF_CNT;
            end else begin
              cnt_d   = cnt_inc;
            end
          end else begin
            // run ended: the unflagged sample is not part of the peak
            emit_s  = 1'b1;
            state_d = ST_REFRAC;
            cnt_d   = REF_CNT;
          end
        end
        ST_REFRAC: begin
          if (cur_cnt <= 8'd1) begin
            state_d = ST_IDLE;
            cnt_d   = 8'd0;
          end else begin
            cnt_d   = cur_cnt - 8'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
        end
      endcase
    end else begin
      emit_s = 1'b0;
    end
    ev_word_s = {time_d, s_axis_b_tchannel, amp_d};
  end

  // Commit the updated context of the sampled channel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHANNEL_COUNT; i++) begin
        state_q[i]     <= ST_IDLE;
        peak_amp_q[i]  <= '0;
        peak_time_q[i] <= '0;
        cnt_q[i]       <= 8'd0;
      end
    end else if (s_axis_b_tsample) begin
      state_q[s_axis_b_tchannel]     <= state_d;
      peak_amp_q[s_axis_b_tchannel]  <= amp_d;
      peak_time_q[s_axis_b_tchannel] <= time_d;
      cnt_q[s_axis_b_tchannel]       <= cnt_d;
    end
  end

  // FIFO control: a pop in the same cycle frees the slot for a push while full
  always_comb begin
    full_s  = (count_q == DEPTH_CNT);
    pop_s   = valid_q & m_axis_c_tready;
    push_s  = emit_s & (~full_s | pop_s);
    drop_s  = emit_s & full_s & ~pop_s;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + {{AW{1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{AW{1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase
  end

  // FIFO pointers, occupancy, registered valid and sticky overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (push_s) wr_ptr_q <= wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
      if (pop_s)  rd_ptr_q <= rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
      count_q <= count_d;
      valid_q <= (count_d != '0);
      if (drop_s) overflow_q <= 1'b1;
    end
  end

  // FIFO storage; contents are only observable while valid
  always_ff @(posedge clk) begin
    if (push_s) mem_q[wr_ptr_q] <= ev_word_s;
  end

  assign head_s          = mem_q[rd_ptr_q];
  assign m_axis_c_tvalid = valid_q;
  assign {m_axis_c_time, m_axis_c_tchannel, m_axis_c_tdata} = valid_q ? head_s : '0;
  assign overflow        = overflow_q;

`ifdef SPIKE_DROP_COUNT_EN
  logic [15:0] drop_cnt_q;

  // Saturating count of events lost to a full FIFO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt_q <= 16'd0;
    end else if (drop_s && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_spike_event_extractor.sv
// Self-checking bench for spike_event_extractor: directed vector table, hand
// sequences for multi-cycle corners, and randomized traffic against a run-list model.
module tb_spike_event_extractor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_axis_b_time;
  logic [4:0]  s_axis_b_tchannel;
  logic [15:0] s_axis_b_tdata;
  logic        s_axis_b_tsample;
  logic        s_axis_b_tvalid;
  logic [31:0] m_axis_c_time;
  logic [4:0]  m_axis_c_tchannel;
  logic [15:0] m_axis_c_tdata;
  logic        m_axis_c_tvalid;
  logic        m_axis_c_tready;
  logic        overflow;
`ifdef SPIKE_DROP_COUNT_EN
  logic [15:0] drop_count;
`endif

  spike_event_extractor dut (
    .clk               (clk),
    .rst               (rst),
    .s_axis_b_time     (s_axis_b_time),
    .s_axis_b_tchannel (s_axis_b_tchannel),
    .s_axis_b_tdata    (s_axis_b_tdata),
    .s_axis_b_tsample  (s_axis_b_tsample),
    .s_axis_b_tvalid   (s_axis_b_tvalid),
    .m_axis_c_time     (m_axis_c_time),
    .m_axis_c_tchannel (m_axis_c_tchannel),
    .m_axis_c_tdata    (m_axis_c_tdata),
    .m_axis_c_tvalid   (m_axis_c_tvalid),
    .m_axis_c_tready   (m_axis_c_tready),
    .overflow          (overflow)
`ifdef SPIKE_DROP_COUNT_EN
    ,
    .drop_count        (drop_count)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: per channel, the list of samples in the open run and the
  // number of samples still to be ignored; the FIFO is a plain queue.
  int          run_len  [32];
  logic [15:0] run_amp  [32][64];
  logic [31:0] run_time [32][64];
  int          hold     [32];
  logic [52:0] mq [$];
  logic        m_ovf;
  int          m_drops;
  logic [52:0] got [$];

  typedef struct {
    logic        smp;
    logic        vld;
    logic [4:0]  ch;
    logic [15:0] amp;
    logic [31:0] t;
    logic        ev;
    logic [52:0] w;
  } vec_t;
  vec_t vecs [12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic void model_clear();
    for (int c = 0; c < 32; c++) begin
      run_len[c] = 0;
      hold[c]    = 0;
    end
    mq.delete();
    m_ovf   = 1'b0;
    m_drops = 0;
  endfunction

  // First largest sample of the run wins
  function automatic logic [52:0] peak_of(input int c);
    int best = 0;
    for (int i = 1; i < run_len[c]; i++)
      if (run_amp[c][i] > run_amp[c][best]) best = i;
    return {run_time[c][best], 5'(c), run_amp[c][best]};
  endfunction

  function automatic void model_update(input logic smp, input logic vld, input logic [4:0] ch,
                                       input logic [15:0] amp, input logic [31:0] t, input logic rdy);
    logic        ev = 1'b0;
    logic [52:0] w  = '0;
    logic        pop;
    int          c  = int'(ch);
    pop = (mq.size() != 0) && rdy;
    if (smp) begin
      if (hold[c] > 0) begin
        hold[c]--;
      end else if (run_len[c] > 0) begin
        if (vld) begin
          run_amp[c][run_len[c]]  = amp;
          run_time[c][run_len[c]] = t;
          run_len[c]++;
          if (run_len[c] == 40) begin
            w = peak_of(c); ev = 1'b1; run_len[c] = 0; hold[c] = 30;
          end
        end else begin
          w = peak_of(c); ev = 1'b1; run_len[c] = 0; hold[c] = 30;
        end
      end else if (vld) begin
        run_amp[c][0]  = amp;
        run_time[c][0] = t;
        run_len[c]     = 1;
      end
    end
    if (pop) void'(mq.pop_front());
    if (ev) begin
      if ((mq.size() < 16)) mq.push_back(w);
      else begin
        m_ovf = 1'b1;
        if (m_drops < 65535) m_drops++;
      end
    end
  endfunction

  task automatic check_model();
    chk("m_valid", 64'(m_axis_c_tvalid), 64'(mq.size() != 0));
    if (mq.size() != 0)
      chk("m_word", 64'({m_axis_c_time, m_axis_c_tchannel, m_axis_c_tdata}), 64'(mq[0]));
    chk("m_overflow", 64'(overflow), 64'(m_ovf));
`ifdef SPIKE_DROP_COUNT_EN
    chk("m_drops", 64'(drop_count), 64'(m_drops));
`endif
  endtask

  // One sample period: drive, check at the falling edge, advance model at the rising edge
  task automatic step(input logic smp, input logic vld, input logic [4:0] ch, input logic [15:0] amp,
                      input logic [31:0] t, input logic rdy, output logic o_v, output logic [52:0] o_w);
    s_axis_b_tsample  = smp;
    s_axis_b_tvalid   = vld;
    s_axis_b_tchannel = ch;
    s_axis_b_tdata    = amp;
    s_axis_b_time     = t;
    m_axis_c_tready   = rdy;
    @(negedge clk);
    o_v = m_axis_c_tvalid;
    o_w = {m_axis_c_time, m_axis_c_tchannel, m_axis_c_tdata};
    check_model();
    if (m_axis_c_tvalid && rdy) got.push_back(o_w);
    @(posedge clk);
    model_update(smp, vld, ch, amp, t, rdy);
    #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    logic        v;
    logic [52:0] w;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0, 16'd0, 32'd0, rdy, v, w);
  endtask

  task automatic pulse_reset();
    s_axis_b_tsample = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_async_valid", 64'(m_axis_c_tvalid), 64'd0);
    @(negedge clk);
    chk("rst_valid", 64'(m_axis_c_tvalid), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  logic        v;
  logic [52:0] w;
  logic [31:0] tcnt;
  logic        r_smp, r_vld, r_rdy;
  logic [4:0]  r_ch;
  logic [15:0] r_amp;

  initial begin
    rst = 1'b1;
    s_axis_b_time = 32'd0; s_axis_b_tchannel = 5'd0; s_axis_b_tdata = 16'd0;
    s_axis_b_tsample = 1'b0; s_axis_b_tvalid = 1'b0; m_axis_c_tready = 1'b0;
    model_clear();
    @(negedge clk);
    chk("reset_valid", 64'(m_axis_c_tvalid), 64'd0);
    chk("reset_word", 64'({m_axis_c_time, m_axis_c_tchannel, m_axis_c_tdata}), 64'd0);
    chk("reset_overflow", 64'(overflow), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed table: expected outputs are those seen during each vector's cycle
    vecs[0]  = '{1'b1, 1'b1, 5'd3, 16'd50,  32'd10, 1'b0, 53'd0};
    vecs[1]  = '{1'b1, 1'b1, 5'd3, 16'd80,  32'd11, 1'b0, 53'd0};
    vecs[2]  = '{1'b1, 1'b1, 5'd3, 16'd70,  32'd12, 1'b0, 53'd0};
    vecs[3]  = '{1'b1, 1'b1, 5'd3, 16'd60,  32'd13, 1'b0, 53'd0};
    vecs[4]  = '{1'b1, 1'b0, 5'd3, 16'd5,   32'd14, 1'b0, 53'd0};
    vecs[5]  = '{1'b0, 1'b0, 5'd0, 16'd0,   32'd0,  1'b1, {32'd11, 5'd3, 16'd80}};
    vecs[6]  = '{1'b1, 1'b1, 5'd3, 16'd200, 32'd15, 1'b0, 53'd0};
    vecs[7]  = '{1'b1, 1'b1, 5'd0, 16'd90,  32'd16, 1'b0, 53'd0};
    vecs[8]  = '{1'b1, 1'b1, 5'd0, 16'd90,  32'd17, 1'b0, 53'd0};
    vecs[9]  = '{1'b1, 1'b0, 5'd0, 16'd0,   32'd18, 1'b0, 53'd0};
    vecs[10] = '{1'b0, 1'b0, 5'd0, 16'd0,   32'd0,  1'b1, {32'd16, 5'd0, 16'd90}};
    vecs[11] = '{1'b0, 1'b0, 5'd0, 16'd0,   32'd0,  1'b0, 53'd0};
    for (int i = 0; i < 12; i++) begin
      step(vecs[i].smp, vecs[i].vld, vecs[i].ch, vecs[i].amp, vecs[i].t, 1'b1, v, w);
      chk($sformatf("vec%0d_valid", i), 64'(v), 64'(vecs[i].ev));
      if (vecs[i].ev) chk($sformatf("vec%0d_word", i), 64'(w), 64'(vecs[i].w));
    end

    // Ch 3 refractory: 29 more flagged samples ignored, the next one opens a spike
    got.delete();
    for (int i = 0; i < 29; i++) step(1'b1, 1'b1, 5'd3, 16'd200, 32'(20 + i), 1'b1, v, w);
    step(1'b1, 1'b1, 5'd3, 16'd77, 32'd100, 1'b1, v, w);
    step(1'b1, 1'b0, 5'd3, 16'd0,  32'd101, 1'b1, v, w);
    idle(2, 1'b1);
    chk("refrac_count", 64'(got.size()), 64'd1);
    chk("refrac_word", 64'(got.size() > 0 ? got[0] : '0), 64'({32'd100, 5'd3, 16'd77}));

    // Ch 5 forced emission at the 40th flagged sample
    got.delete();
    for (int i = 0; i < 45; i++) step(1'b1, 1'b1, 5'd5, 16'(1000 + i), 32'(200 + i), 1'b1, v, w);
    step(1'b1, 1'b0, 5'd5, 16'd0, 32'd245, 1'b1, v, w);
    idle(2, 1'b1);
    chk("maxw_count", 64'(got.size()), 64'd1);
    chk("maxw_word", 64'(got.size() > 0 ? got[0] : '0), 64'({32'd239, 5'd5, 16'd1039}));

    // Backpressure: 20 single-sample spikes, 16 retained
    for (int c = 8; c < 28; c++) begin
      step(1'b1, 1'b1, 5'(c), 16'(c * 10 + 3), 32'(300 + 2 * (c - 8)), 1'b0, v, w);
      step(1'b1, 1'b0, 5'(c), 16'd0, 32'(301 + 2 * (c - 8)), 1'b0, v, w);
    end
    step(1'b0, 1'b0, 5'd0, 16'd0, 32'd0, 1'b0, v, w);
    chk("ovf_head_valid", 64'(v), 64'd1);
    chk("ovf_head_word", 64'(w), 64'({32'd300, 5'd8, 16'd83}));
    chk("ovf_flag", 64'(overflow), 64'd1);
`ifdef SPIKE_DROP_COUNT_EN
    chk("ovf_drop_count", 64'(drop_count), 64'd4);
`endif
    got.delete();
    idle(16, 1'b1);
    chk("drain_count16", 64'(got.size()), 64'd16);
    for (int i = 0; i < 16; i++)
      chk($sformatf("drain_word%0d", i), 64'(got.size() > i ? got[i] : '0),
          64'({32'(300 + 2 * i), 5'(8 + i), 16'((8 + i) * 10 + 3)}));
    idle(2, 1'b1);
    chk("drain_count_final", 64'(got.size()), 64'd16);

    // Reset with ch 7 open and three events queued
    for (int c = 28; c < 31; c++) begin
      step(1'b1, 1'b1, 5'(c), 16'(c), 32'(400 + 2 * (c - 28)), 1'b0, v, w);
      step(1'b1, 1'b0, 5'(c), 16'd0, 32'(401 + 2 * (c - 28)), 1'b0, v, w);
    end
    step(1'b1, 1'b1, 5'd7, 16'd999, 32'd410, 1'b0, v, w);
    chk("prerst_valid", 64'(m_axis_c_tvalid), 64'd1);
    pulse_reset();
    got.delete();
    step(1'b1, 1'b1, 5'd7, 16'd55, 32'd500, 1'b1, v, w);
    step(1'b1, 1'b0, 5'd7, 16'd0,  32'd501, 1'b1, v, w);
    idle(2, 1'b1);
    chk("postrst_count", 64'(got.size()), 64'd1);
    chk("postrst_word", 64'(got.size() > 0 ? got[0] : '0), 64'({32'd500, 5'd7, 16'd55}));

    // Interleaved channels 0 and 31
    got.delete();
    for (int k = 0; k < 4; k++) begin
      r_amp = (k == 0) ? 16'd10 : (k == 1) ? 16'd40 : (k == 2) ? 16'd30 : 16'd20;
      step(1'b1, 1'b1, 5'd0, r_amp, 32'(600 + 2 * k), 1'b1, v, w);
      r_amp = (k == 0) ? 16'd70 : (k == 1) ? 16'd60 : (k == 2) ? 16'd90 : 16'd80;
      step(1'b1, 1'b1, 5'd31, r_amp, 32'(601 + 2 * k), 1'b1, v, w);
    end
    step(1'b1, 1'b0, 5'd0,  16'd0, 32'd608, 1'b1, v, w);
    step(1'b1, 1'b0, 5'd31, 16'd0, 32'd609, 1'b1, v, w);
    idle(3, 1'b1);
    chk("ilv_count", 64'(got.size()), 64'd2);
    chk("ilv_ch0", 64'(got.size() > 0 ? got[0] : '0), 64'({32'd602, 5'd0, 16'd40}));
    chk("ilv_ch31", 64'(got.size() > 1 ? got[1] : '0), 64'({32'd605, 5'd31, 16'd90}));

    // Randomized traffic against the model, time wrapping through zero
    tcnt = 32'hFFFF_FF00;
    for (int n = 0; n < 4000; n++) begin
      r_smp = ($urandom_range(0, 3) != 0);
      r_vld = ($urandom_range(0, 9) < 8);
      r_ch  = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      r_amp = 16'($urandom_range(0, 65535));
      r_rdy = ($urandom_range(0, 9) < 7);
      step(r_smp, r_vld, r_ch, r_amp, tcnt, r_rdy, v, w);
      if (r_smp) tcnt = tcnt + 32'd1;
    end
    idle(20, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
